// File: rtl/cc_channel_sched_if.sv
// Handshake bundle between the requesters/datapath and the cc channel scheduler.
// The scheduler sits on the slave side; the requester/datapath side is the master.
interface cc_channel_sched_if #(
    parameter int NREQ    = 8,
    parameter int BURST_W = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                    en;
    logic [NREQ-1:0]         req;
    logic [NREQ*BURST_W-1:0] len;
    logic                    ready;
    logic [NREQ-1:0]         gnt;
    logic [IDW-1:0]          gnt_id;
    logic                    busy;
    logic                    beat;
    logic                    done;
    logic                    abort;
    logic                    timeout;

    modport master (
        output en, req, len, ready,
        input  gnt, gnt_id, busy, beat, done, abort, timeout
    );

    modport slave (
        input  en, req, len, ready,
        output gnt, gnt_id, busy, beat, done, abort, timeout
    );
endinterface

// File: rtl/cc_channel_sched.sv
// Round-robin scheduler sharing the cc output channel between NREQ requesters,
// granting bursts of len+1 beats with early cut on withdrawal, disable or stall.
//
// state | meaning
// IDLE  | no grant; arbitrate among requests when en is high
// XFER  | grant held; beats counted down, stall cycles counted up
// GAP   | one dead cycle, grant cleared, done/abort/timeout pulse visible
module cc_channel_sched #(
    parameter int NREQ    = 8,
    parameter int BURST_W = 4,
    parameter int TMO     = 15
) (
    input logic               clk,
    input logic               rst,
    cc_channel_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] STALL_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state;
    logic [NREQ-1:0]      gnt;
    logic [IDW-1:0]       gnt_id;
    logic                 busy;
    logic                 done;
    logic                 abort;
    logic                 timeout;
    logic [IDW-1:0]       last_id;
    logic [BURST_W-1:0]   cnt;
    logic [7:0]           stall;

    logic [BURST_W-1:0]   len_arr [NREQ];
    logic [IDW-1:0]       win;
    logic [IDW-1:0]       idx;
    logic                 found;
    logic                 beat;

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign len_arr[g] = bus.len[g*BURST_W +: BURST_W];
    end

    // Search starts just after the last winner so the requester just served
    // drops to lowest priority.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last_id) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign beat = (state == XFER) & bus.ready & bus.en & bus.req[gnt_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
            timeout <= 1'b0;
            last_id <= IDW'(NREQ - 1);
            cnt     <= '0;
            stall   <= '0;
        end else begin
            done    <= 1'b0;
            abort   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && found) begin
                        state   <= XFER;
                        gnt_id  <= win;
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        cnt     <= len_arr[win];
                        stall   <= '0;
                        last_id <= win;
                        busy    <= 1'b1;
                    end
                end
                XFER: begin
                    if (!bus.en || !bus.req[gnt_id]) begin
                        abort  <= 1'b1;
                        state  <= GAP;
                        gnt    <= '0;
                        gnt_id <= '0;
                    end else if (beat && cnt == '0) begin
                        done   <= 1'b1;
                        state  <= GAP;
                        gnt    <= '0;
                        gnt_id <= '0;
                    end else if (beat) begin
                        cnt   <= cnt - 1'b1;
                        stall <= '0;
                    end else if (!bus.ready) begin
                        if (stall != 8'hFF)
                            stall <= stall + 8'd1;
                        if (stall == STALL_LAST) begin
                            timeout <= 1'b1;
                            state   <= GAP;
                            gnt     <= '0;
                            gnt_id  <= '0;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    gnt_id <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_id  = gnt_id;
    assign bus.busy    = busy;
    assign bus.beat    = beat;
    assign bus.done    = done;
    assign bus.abort   = abort;
    assign bus.timeout = timeout;
endmodule
